// File: rtl/scr1_dmem_router_np_if.sv
// Core-side and target-side bus bundles for the N-port data memory router.
// master drives requests, slave returns acknowledges and responses.
interface scr1_dmem_if;
    logic        dmem_req;
    logic        dmem_req_ack;
    logic        dmem_cmd;
    logic [1:0]  dmem_width;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic [1:0]  dmem_resp;

    modport master (
        output dmem_req,
        output dmem_cmd,
        output dmem_width,
        output dmem_addr,
        output dmem_wdata,
        input  dmem_req_ack,
        input  dmem_rdata,
        input  dmem_resp
    );

    modport slave (
        input  dmem_req,
        input  dmem_cmd,
        input  dmem_width,
        input  dmem_addr,
        input  dmem_wdata,
        output dmem_req_ack,
        output dmem_rdata,
        output dmem_resp
    );
endinterface

interface scr1_dmem_port_if #(
    parameter int PORT_NUM = 3
);
    logic [PORT_NUM-1:0]    port_req;
    logic [PORT_NUM-1:0]    port_req_ack;
    logic [PORT_NUM-1:0]    port_cmd;
    logic [2*PORT_NUM-1:0]  port_width;
    logic [32*PORT_NUM-1:0] port_addr;
    logic [32*PORT_NUM-1:0] port_wdata;
    logic [32*PORT_NUM-1:0] port_rdata;
    logic [2*PORT_NUM-1:0]  port_resp;

    modport master (
        output port_req,
        output port_cmd,
        output port_width,
        output port_addr,
        output port_wdata,
        input  port_req_ack,
        input  port_rdata,
        input  port_resp
    );

    modport slave (
        input  port_req,
        input  port_cmd,
        input  port_width,
        input  port_addr,
        input  port_wdata,
        output port_req_ack,
        output port_rdata,
        output port_resp
    );
endinterface

// File: rtl/scr1_dmem_router_np.sv
// N-port data memory router: decodes core requests onto mask/pattern windows,
// tracks one outstanding transaction and answers unmapped addresses locally.
module scr1_dmem_router_np #(
    parameter int                          SCR1_PORT_NUM     = 3,
    parameter logic [SCR1_PORT_NUM*32-1:0] SCR1_ADDR_MASK    = {32'hFFFFFFE0, 32'hFFFF0000, 32'h0},
    parameter logic [SCR1_PORT_NUM*32-1:0] SCR1_ADDR_PATTERN = {32'h00490000, 32'h00480000, 32'h0},
    parameter bit                          SCR1_DEFAULT_EN   = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    scr1_dmem_if.slave              dmem_if,
    scr1_dmem_port_if.master        port_if
);

    localparam int SEL_W = (SCR1_PORT_NUM > 2) ? $clog2(SCR1_PORT_NUM) : 1;

    localparam logic [1:0] RESP_IDLE = 2'd0;
    localparam logic [1:0] RESP_ER   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_MISS
    } state_e;

    if ((SCR1_PORT_NUM < 2) || (SCR1_PORT_NUM > 8)) begin : g_port_num_check
        $fatal(1, "scr1_dmem_router_np: SCR1_PORT_NUM must be in 2..8");
    end

    state_e                   state_q;
    state_e                   state_d;
    logic [SEL_W-1:0]         sel_q;
    logic [SEL_W-1:0]         sel_d;

    logic [SCR1_PORT_NUM-1:0] hit;
    logic [SEL_W-1:0]         dec_sel;
    logic                     dec_hit;
    logic                     dec_miss;

    logic                     accept_en;
    logic [SCR1_PORT_NUM-1:0] req_vec;
    logic                     req_ack;
    logic [31:0]              rsp_data;
    logic [1:0]               rsp_code;

    // Port 0 has no window; it only ever receives the fallback traffic.
    always_comb begin
        hit = '0;
        for (int i = 1; i < SCR1_PORT_NUM; i++) begin
            hit[i] = ((dmem_if.dmem_addr & SCR1_ADDR_MASK[i*32 +: 32]) == SCR1_ADDR_PATTERN[i*32 +: 32]);
        end
    end

    always_comb begin
        dec_sel = '0;
        dec_hit = 1'b0;
        for (int i = SCR1_PORT_NUM - 1; i >= 1; i--) begin
            if (hit[i]) begin
                dec_sel = SEL_W'(i);
                dec_hit = 1'b1;
            end
        end
        dec_miss = !dec_hit && !SCR1_DEFAULT_EN;
    end

    assign port_if.port_cmd   = {SCR1_PORT_NUM{dmem_if.dmem_cmd}};
    assign port_if.port_width = {SCR1_PORT_NUM{dmem_if.dmem_width}};
    assign port_if.port_addr  = {SCR1_PORT_NUM{dmem_if.dmem_addr}};
    assign port_if.port_wdata = {SCR1_PORT_NUM{dmem_if.dmem_wdata}};

    // A response cycle in WAIT reopens the accept path for zero-bubble issue.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        rsp_data  = '0;
        rsp_code  = RESP_IDLE;
        accept_en = 1'b0;
        req_vec   = '0;
        req_ack   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                accept_en = 1'b1;
            end
            ST_WAIT: begin
                rsp_data = port_if.port_rdata[sel_q*32 +: 32];
                rsp_code = port_if.port_resp[sel_q*2 +: 2];
                if (rsp_code != RESP_IDLE) begin
                    accept_en = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_MISS: begin
                rsp_code = RESP_ER;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (!rst_n) begin
            accept_en = 1'b0;
            rsp_code  = RESP_IDLE;
            rsp_data  = '0;
        end

        if (accept_en && dmem_if.dmem_req) begin
            if (dec_miss) begin
                req_ack = 1'b1;
                state_d = ST_MISS;
            end else begin
                req_vec[dec_sel] = 1'b1;
                req_ack          = port_if.port_req_ack[dec_sel];
                if (req_ack) begin
                    state_d = ST_WAIT;
                    sel_d   = dec_sel;
                end
            end
        end
    end

    assign port_if.port_req     = req_vec;
    assign dmem_if.dmem_req_ack = req_ack;
    assign dmem_if.dmem_rdata   = rsp_data;
    assign dmem_if.dmem_resp    = rsp_code;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
        end
    end

endmodule

// File: tb/tb_scr1_dmem_router_np.sv
// Directed bench for the N-port router: a default 3-port fallback instance and a
// 4-port instance with local miss handling and overlapping windows.
module tb_scr1_dmem_router_np;

    logic clk;
    logic rst_n;

    int checks;
    int failures;

    scr1_dmem_if             coreA ();
    scr1_dmem_port_if #(3)   portA ();
    scr1_dmem_if             coreB ();
    scr1_dmem_port_if #(4)   portB ();

    scr1_dmem_router_np dutA (
        .clk     (clk),
        .rst_n   (rst_n),
        .dmem_if (coreA),
        .port_if (portA)
    );

    scr1_dmem_router_np #(
        .SCR1_PORT_NUM     (4),
        .SCR1_ADDR_MASK    ({32'hFFFF0000, 32'hFFFFFFE0, 32'hFFFF0000, 32'h0}),
        .SCR1_ADDR_PATTERN ({32'h00490000, 32'h00490000, 32'h00480000, 32'h0}),
        .SCR1_DEFAULT_EN   (1'b0)
    ) dutB (
        .clk     (clk),
        .rst_n   (rst_n),
        .dmem_if (coreB),
        .port_if (portB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input bit sideB, input logic req, input logic cmd, input logic [31:0] addr, input logic [31:0] wdata);
        if (sideB) begin
            coreB.dmem_req   = req;
            coreB.dmem_cmd   = cmd;
            coreB.dmem_width = 2'd2;
            coreB.dmem_addr  = addr;
            coreB.dmem_wdata = wdata;
        end else begin
            coreA.dmem_req   = req;
            coreA.dmem_cmd   = cmd;
            coreA.dmem_width = 2'd2;
            coreA.dmem_addr  = addr;
            coreA.dmem_wdata = wdata;
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h00480010, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        portA.port_req_ack = '1;
        portA.port_rdata   = '0;
        portA.port_resp    = '0;
        portB.port_req_ack = '0;
        portB.port_rdata   = '0;
        portB.port_resp    = '0;

        tick();
        tick();
        checkOutput("rst_port_req", portA.port_req, 128'h0);
        checkOutput("rst_req_ack", coreA.dmem_req_ack, 128'h0);
        checkOutput("rst_resp", coreA.dmem_resp, 128'h0);
        checkOutput("rst_rdata", coreA.dmem_rdata, 128'h0);

        // Single read to port 1 (TCM window)
        rst_n = 1'b1;
        portA.port_req_ack = 3'b010;
        #1;
        checkOutput("rd_port_req", portA.port_req, 128'h2);
        checkOutput("rd_req_ack", coreA.dmem_req_ack, 128'h1);
        checkOutput("rd_port_addr", portA.port_addr, {32'h0, {3{32'h00480010}}});
        checkOutput("rd_port_width", portA.port_width, 128'h2A);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        portA.port_req_ack = '0;
        #1;
        checkOutput("rd_wait_resp", coreA.dmem_resp, 128'h0);
        checkOutput("rd_wait_port_req", portA.port_req, 128'h0);
        tick();
        portA.port_resp  = 6'b10_01_00;
        portA.port_rdata = {32'h12345678, 32'hDEADBEEF, 32'h87654321};
        #1;
        checkOutput("rd_resp", coreA.dmem_resp, 128'h1);
        checkOutput("rd_rdata", coreA.dmem_rdata, 128'hDEADBEEF);
        tick();
        portA.port_resp  = 6'b00_01_00;
        portA.port_rdata = {32'h0, 32'h0000FFFF, 32'h0};
        #1;
        checkOutput("rd_idle_resp", coreA.dmem_resp, 128'h0);
        checkOutput("rd_idle_rdata", coreA.dmem_rdata, 128'h0);
        portA.port_resp  = '0;
        portA.port_rdata = '0;

        // Back-to-back: write to port 2, then read to port 1 issued on its response cycle
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h00490004, 32'hA0A0A0A0);
        portA.port_req_ack = 3'b100;
        #1;
        checkOutput("b2b_wr_port_req", portA.port_req, 128'h4);
        checkOutput("b2b_wr_wdata", portA.port_wdata, {32'h0, {3{32'hA0A0A0A0}}});
        checkOutput("b2b_wr_cmd", portA.port_cmd, 128'h7);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h00480000, 32'h0);
        portA.port_req_ack = 3'b010;
        portA.port_resp    = 6'b01_00_00;
        portA.port_rdata   = {32'h11112222, 32'h0, 32'h0};
        #1;
        checkOutput("b2b_resp", coreA.dmem_resp, 128'h1);
        checkOutput("b2b_req_ack", coreA.dmem_req_ack, 128'h1);
        checkOutput("b2b_port_req", portA.port_req, 128'h2);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        portA.port_req_ack = '0;
        portA.port_resp    = 6'b00_01_00;
        portA.port_rdata   = {32'h0, 32'hCAFEF00D, 32'h0};
        #1;
        checkOutput("b2b_rd_resp", coreA.dmem_resp, 128'h1);
        checkOutput("b2b_rd_rdata", coreA.dmem_rdata, 128'hCAFEF00D);
        tick();
        portA.port_resp  = '0;
        portA.port_rdata = '0;

        // Fallback to port 0 with an error passed through
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h20000000, 32'h0);
        portA.port_req_ack = 3'b001;
        #1;
        checkOutput("fb_port_req", portA.port_req, 128'h1);
        checkOutput("fb_req_ack", coreA.dmem_req_ack, 128'h1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        portA.port_req_ack = '0;
        portA.port_resp    = 6'b00_00_10;
        #1;
        checkOutput("fb_resp_er", coreA.dmem_resp, 128'h2);
        tick();
        portA.port_resp = '0;

        // Stall on port 1, then reset discards the late response
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h00480020, 32'h0);
        portA.port_req_ack = 3'b010;
        #1;
        checkOutput("stall_issue_ack", coreA.dmem_req_ack, 128'h1);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h00490000, 32'h0);
        portA.port_req_ack = 3'b111;
        for (int i = 0; i < 5; i++) begin
            #1;
            checkOutput($sformatf("stall_ack_%0d", i), coreA.dmem_req_ack, 128'h0);
            checkOutput($sformatf("stall_port_req_%0d", i), portA.port_req, 128'h0);
            tick();
        end
        rst_n = 1'b0;
        #1;
        checkOutput("stall_rst_port_req", portA.port_req, 128'h0);
        checkOutput("stall_rst_ack", coreA.dmem_req_ack, 128'h0);
        tick();
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        portA.port_req_ack = '0;
        portA.port_resp    = 6'b00_01_00;
        portA.port_rdata   = {32'h0, 32'h00000055, 32'h0};
        #1;
        checkOutput("late_resp", coreA.dmem_resp, 128'h0);
        checkOutput("late_rdata", coreA.dmem_rdata, 128'h0);
        tick();
        portA.port_resp  = '0;
        portA.port_rdata = '0;

        // Unmapped address on the local-error instance
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h20000000, 32'h0);
        portB.port_req_ack = 4'b1111;
        #1;
        checkOutput("miss_req_ack", coreB.dmem_req_ack, 128'h1);
        checkOutput("miss_port_req", portB.port_req, 128'h0);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h00480000, 32'h0);
        portB.port_rdata = {4{32'hFFFFFFFF}};
        #1;
        checkOutput("miss_resp", coreB.dmem_resp, 128'h2);
        checkOutput("miss_rdata", coreB.dmem_rdata, 128'h0);
        checkOutput("miss_no_accept", coreB.dmem_req_ack, 128'h0);
        checkOutput("miss_no_port_req", portB.port_req, 128'h0);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        portB.port_rdata = '0;
        #1;
        checkOutput("miss_done_resp", coreB.dmem_resp, 128'h0);

        // Overlapping windows: port 2 beats port 3, port 3 alone outside port 2's window
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h00490008, 32'h0);
        #1;
        checkOutput("ovl_port_req", portB.port_req, 128'h4);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        portB.port_resp  = 8'b10_01_00_00;
        portB.port_rdata = {32'h0000FFFF, 32'h0000A5A5, 32'h0, 32'h0};
        #1;
        checkOutput("ovl_resp", coreB.dmem_resp, 128'h1);
        checkOutput("ovl_rdata", coreB.dmem_rdata, 128'hA5A5);
        tick();
        portB.port_resp  = '0;
        portB.port_rdata = '0;
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h00490100, 32'h0);
        #1;
        checkOutput("p3_port_req", portB.port_req, 128'h8);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        portB.port_resp  = 8'b01_10_00_00;
        portB.port_rdata = {32'h00003333, 32'h00004444, 32'h0, 32'h0};
        #1;
        checkOutput("p3_resp", coreB.dmem_resp, 128'h1);
        checkOutput("p3_rdata", coreB.dmem_rdata, 128'h3333);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/scr1_dmem_router_np.md
Name: scr1_dmem_router_np

Overview:
- Parametrised N-port successor to the 2-port data memory router.
- Sits between the core dmem interface and up to 8 targets: AHB bridge, TCM, timer, and future peripherals.
- Decodes each request address against per-port mask/pattern windows and forwards it to one port.
- Tracks one outstanding transaction, supports back-to-back issue on the response cycle, and generates a local error response for unmapped addresses.

Parameters:
- SCR1_PORT_NUM, 3, number of target ports; legal range 2..8. Port 0 is the fallback port.
- SCR1_ADDR_MASK, {32'hFFFFFFE0, 32'hFFFF0000, 32'h0}, packed [SCR1_PORT_NUM*32-1:0]; slice i is the mask for port i. Slice 0 is unused.
- SCR1_ADDR_PATTERN, {32'h00490000, 32'h00480000, 32'h0}, packed per-port pattern; slice 0 is unused.
- SCR1_DEFAULT_EN, 1, 1 = unmatched addresses go to port 0; 0 = unmatched addresses get a local error response.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- dmem_req  in  1  core request
- dmem_req_ack  out  1  request accepted
- dmem_cmd  in  1  0=RD, 1=WR
- dmem_width  in  2  0=BYTE, 1=HWORD, 2=WORD
- dmem_addr  in  32  address
- dmem_wdata  in  32  write data
- dmem_rdata  out  32  read data to core
- dmem_resp  out  2  0=IDLE, 1=RDY, 2=ER
- port_req  out  N  per-port request
- port_req_ack  in  N  per-port accept
- port_cmd  out  N  broadcast of dmem_cmd
- port_width  out  2N  broadcast of dmem_width
- port_addr  out  32N  broadcast of dmem_addr
- port_wdata  out  32N  broadcast of dmem_wdata
- port_rdata  in  32N  per-port read data
- port_resp  in  2N  per-port response

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- Address decode (combinational):
  - hit[i] = ((dmem_addr & MASK[i]) == PATTERN[i]), evaluated for i = 1..N-1.
  - sel = lowest i with hit[i].
  - If no hit: sel = 0 when SCR1_DEFAULT_EN=1, otherwise miss = 1.
- Broadcast fields: cmd, width, addr and wdata go to all ports unconditionally. Only port_req is qualified.
- FSM states:
  - IDLE: no transaction outstanding.
  - WAIT: request forwarded; waiting for a response from sel_r.
  - MISS: unmapped request accepted; local error pending.
- Accept logic, active in IDLE, and in WAIT on the response cycle:
  - Hit case: port_req[sel] = dmem_req, all other port_req = 0, dmem_req_ack = port_req_ack[sel].
  - On acknowledged request: sel_r <= sel, next state WAIT.
  - Miss case: dmem_req_ack = 1 and no port_req is asserted; next state MISS.
- WAIT behaviour:
  - dmem_rdata = port_rdata[sel_r] and dmem_resp = port_resp[sel_r].
  - If port_resp[sel_r] == IDLE: no new accept; all port_req = 0; dmem_req_ack = 0.
  - If port_resp[sel_r] is RDY or ER: the response is passed through the same cycle, and the accept logic is enabled in that same cycle (zero-bubble back-to-back).
  - If no new request is acknowledged on that cycle, next state IDLE.
- MISS behaviour:
  - dmem_resp = ER, dmem_rdata = 0, next state IDLE.
  - No accept in this cycle; dmem_req_ack = 0.
- IDLE outputs: dmem_resp = IDLE, dmem_rdata = 0.
- Responses from non-selected ports are ignored in every state.
- Reset values: state = IDLE, sel_r = 0, dmem_req_ack = 0, all port_req = 0, dmem_resp = IDLE, dmem_rdata = 0.
- Reset mid-transaction: state returns to IDLE; any pending port response is discarded. Targets are reset by the same rst_n.
- Latency:
  - Router adds 0 cycles on the request path and 0 cycles on the response path.
  - A miss responds exactly 1 cycle after acceptance.
- Priority: on overlapping windows, the lowest port index wins. Port 0 is never decoded by its window.
- Elaboration check: SCR1_PORT_NUM outside 2..8 is a fatal elaboration error.

Test Plan:
- Single read to TCM: RD at 0x00480010, port1 ack at cycle 0, port1 resp RDY with rdata 0xDEADBEEF at cycle 2 -> only port_req[1] asserted; core sees RDY/0xDEADBEEF at cycle 2; state returns to IDLE.
- Back-to-back: WR to 0x00490004 (port2) responds RDY while the core already requests RD at 0x00480000 -> dmem_req_ack=1 in the response cycle; port_req[1] asserted in that same cycle; no idle bubble.
- Fallback: SCR1_DEFAULT_EN=1, RD at 0x20000000 -> routed to port0; port0 ER is passed through as dmem_resp=ER.
- Unmapped: SCR1_DEFAULT_EN=0, RD at 0x20000000 -> dmem_req_ack=1 with no port_req; next cycle dmem_resp=ER, rdata=0; the following cycle ignores dmem_req.
- Stall and reset: port1 holds resp=IDLE for 5 cycles -> dmem_req_ack stays 0 for new requests. Then rst_n=0 for one cycle -> state IDLE, all port_req=0; a late port1 RDY is not forwarded.
- Window overlap: N=4 with port2 and port3 both matching 0x00490000 -> port2 is selected.
